// File: rtl/keypad_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_scan                                                   |
// | Purpose  : 4x4 active-low matrix keypad scanner. Drives one row low at   |
// |            a time, samples the columns through a 2-FF synchronizer,      |
// |            builds a 16-bit frame per full row sweep and debounces whole  |
// |            frames. Emits one key code per debounced single-key press.    |
// | Ports    : clk       - system clock                                      |
// |            rst       - synchronous reset, active-high                    |
// |            row[3:0]  - row drive, active-low, exactly one bit low        |
// |            col[3:0]  - column sense, active-low, asynchronous to clk     |
// |            key_code  - last accepted key, 4*row_index + col_index        |
// |            key_valid - one-cycle pulse when a new key is accepted        |
// |            key_down  - high while the accepted key is held               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_scan #(
  parameter int SCAN_DIV = 100000,  // clk cycles per row slot, >= 4
  parameter int DEBOUNCE = 3        // identical frames to accept, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  // ------------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------------
  localparam int               c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       c_DEB_MAX  = 4'(DEBOUNCE);

  // Candidate kind, upper two bits of a 6-bit candidate {kind, code}.
  // The code field is forced to zero for NONE and MULTI so that a plain
  // equality compare between candidates is meaningful.
  localparam logic [1:0] c_CAND_NONE   = 2'd0;
  localparam logic [1:0] c_CAND_SINGLE = 2'd1;
  localparam logic [1:0] c_CAND_MULTI  = 2'd2;

  localparam logic [0:0] c_ST_IDLE    = 1'b0;
  localparam logic [0:0] c_ST_PRESSED = 1'b1;

  // ------------------------------------------------------------------------
  // Column synchronizer
  // ------------------------------------------------------------------------
  logic [3:0] col_meta_q;
  logic [3:0] col_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // ------------------------------------------------------------------------
  // Row-slot divider
  // ------------------------------------------------------------------------
  logic [c_DIV_W-1:0] div_cnt_q;
  logic [c_DIV_W-1:0] div_cnt_d;
  logic               w_tick;

  assign w_tick = (div_cnt_q == c_DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + c_DIV_W'(1);
    if (w_tick) begin
      div_cnt_d = '0;
    end
  end

  // ------------------------------------------------------------------------
  // Row scan
  // ------------------------------------------------------------------------
  logic [1:0] row_idx_q;
  logic [1:0] row_idx_d;
  logic [3:0] row_q;
  logic [3:0] row_d;

  always_comb begin
    row_idx_d = row_idx_q;
    row_d     = row_q;
    if (w_tick) begin
      row_idx_d = row_idx_q + 2'd1;
      row_d     = ~(4'b0001 << row_idx_d);
    end
  end

  // ------------------------------------------------------------------------
  // Frame buffer
  // Only rows 0..2 are stored: the row 3 sample is taken on the same tick
  // that closes the frame, so it is consumed straight from the synchronizer.
  // ------------------------------------------------------------------------
  logic [3:0] frame_q [0:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        frame_q[i] <= 4'b1111;
      end
    end else if (w_tick) begin
      case (row_idx_q)
        2'd0:    frame_q[0] <= col_sync_q;
        2'd1:    frame_q[1] <= col_sync_q;
        2'd2:    frame_q[2] <= col_sync_q;
        default: ;
      endcase
    end
  end

  // Active-high pressed map, bit index = 4*row + col.
  logic [15:0] w_pressed;

  for (genvar gr = 0; gr < 4; gr++) begin : g_frame_row
    if (gr == 3) begin : g_live
      assign w_pressed[4*gr +: 4] = ~col_sync_q;
    end else begin : g_buf
      assign w_pressed[4*gr +: 4] = ~frame_q[gr];
    end
  end

  logic w_frame_end;
  assign w_frame_end = w_tick && (row_idx_q == 2'd3);

  // ------------------------------------------------------------------------
  // Frame candidate classification
  // ------------------------------------------------------------------------
  logic [4:0] w_press_cnt;
  logic [3:0] w_press_idx;
  logic [1:0] w_cand_kind;
  logic [5:0] w_cand;

  always_comb begin
    w_press_cnt = '0;
    w_press_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_pressed[i]) begin
        w_press_cnt = w_press_cnt + 5'd1;
        w_press_idx = 4'(i);
      end
    end

    if (w_press_cnt == 5'd0) begin
      w_cand_kind = c_CAND_NONE;
    end else if (w_press_cnt == 5'd1) begin
      w_cand_kind = c_CAND_SINGLE;
    end else begin
      w_cand_kind = c_CAND_MULTI;
    end

    w_cand = {w_cand_kind, (w_cand_kind == c_CAND_SINGLE) ? w_press_idx : 4'd0};
  end

  // ------------------------------------------------------------------------
  // Frame debounce
  // w_accept marks the frame-end cycle where the stable count reaches
  // DEBOUNCE; the debounced state then becomes the current candidate.
  // A saturated count that merely stays saturated is not a new acceptance.
  // ------------------------------------------------------------------------
  logic [5:0] prev_q;
  logic [5:0] prev_d;
  logic [3:0] stable_q;
  logic [3:0] stable_d;
  logic       w_accept;

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    w_accept = 1'b0;
    if (w_frame_end) begin
      if (w_cand == prev_q) begin
        if (stable_q < c_DEB_MAX) begin
          stable_d = stable_q + 4'd1;
        end
      end else begin
        prev_d   = w_cand;
        stable_d = 4'd1;
      end
      w_accept = (stable_d == c_DEB_MAX) &&
                 ((stable_q != c_DEB_MAX) || (w_cand != prev_q));
    end
  end

  logic w_acc_single;
  logic w_acc_none;

  assign w_acc_single = w_accept && (w_cand_kind == c_CAND_SINGLE);
  assign w_acc_none   = w_accept && (w_cand_kind == c_CAND_NONE);

  // ------------------------------------------------------------------------
  // Key FSM: state register
  // ------------------------------------------------------------------------
  logic [0:0] state_q;
  logic [0:0] state_d;
  logic [3:0] key_code_q;
  logic [3:0] key_code_d;
  logic       key_valid_q;
  logic       key_valid_d;
  logic       key_down_q;
  logic       key_down_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      prev_q      <= {c_CAND_NONE, 4'd0};
      stable_q    <= 4'd0;
      state_q     <= c_ST_IDLE;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  // ------------------------------------------------------------------------
  // Key FSM: next state
  // Once a key is accepted, only a debounced NONE releases the FSM, so no
  // rollover to a second key is possible while anything is held.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_acc_single) begin
          state_d = c_ST_PRESSED;
        end
      end
      c_ST_PRESSED: begin
        if (w_acc_none) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Key FSM: outputs
  // key_valid_d is defaulted low every cycle, so the registered pulse can
  // never last more than one cycle.
  // ------------------------------------------------------------------------
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_acc_single) begin
          key_code_d  = w_press_idx;
          key_valid_d = 1'b1;
          key_down_d  = 1'b1;
        end
      end
      c_ST_PRESSED: begin
        if (w_acc_none) begin
          key_down_d = 1'b0;
        end
      end
      default: begin
        key_down_d = 1'b0;
      end
    endcase
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_keypad_scan                                                |
// | Purpose  : Self-checking bench for keypad_scan. A keypad model closes    |
// |            the row/column loop; a frame-level reference model predicts   |
// |            row drive, key_valid, key_down and key_code every cycle.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = '0;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Keypad: column c pulled low when the driven-low row has key (r,c) down.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row[r] == 1'b0 && keys[4*r+c]) begin
          col[c] = 1'b0;
        end
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: candidate as integer (-1 none, 0..15 key, 16 multi)
  int         m_prev;
  int         m_run;
  bit         m_pressed;
  logic [3:0] m_code;
  bit         m_valid;
  logic       prev_kv;

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prev    = -1;
    m_run     = 0;
    m_pressed = 0;
    m_code    = 4'd0;
    m_valid   = 0;
    prev_kv   = 1'b0;
  endtask

  // One frame's worth of keys judged as a whole.
  task automatic model_frame();
    int cnt  = 0;
    int idx  = 0;
    int cand;
    for (int i = 0; i < 16; i++) begin
      if (keys[i]) begin
        cnt++;
        idx = i;
      end
    end
    cand = (cnt == 0) ? -1 : ((cnt == 1) ? idx : 16);
    if (cand == m_prev) m_run++;
    else begin
      m_prev = cand;
      m_run  = 1;
    end
    m_valid = 0;
    if (m_run == DEBOUNCE) begin
      if (!m_pressed && cand >= 0 && cand < 16) begin
        m_pressed = 1;
        m_code    = 4'(cand);
        m_valid   = 1;
      end else if (m_pressed && cand < 0) begin
        m_pressed = 0;
      end
    end
  endtask

  // Advance one clock and check every output at the following falling edge.
  task automatic step();
    logic [3:0] one_hot;
    logic [3:0] exp_row;
    @(negedge clk);
    cyc++;
    if (cyc % FRAME == 0) model_frame();
    else m_valid = 0;
    one_hot = 4'b0001 << ((cyc / SCAN_DIV) % 4);
    exp_row = ~one_hot;
    check_val("row", {12'd0, row}, {12'd0, exp_row});
    check_val("key_valid", {15'd0, key_valid}, {15'd0, m_valid});
    check_val("key_down", {15'd0, key_down}, {15'd0, m_pressed});
    check_val("key_code", {12'd0, key_code}, {12'd0, m_code});
    check_val("kv_back_to_back", {15'd0, key_valid & prev_kv}, 16'd0);
    prev_kv = key_valid;
  endtask

  // Reset asserted for exactly one rising edge, from wherever we are.
  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    model_reset();
    check_val("rst_row", {12'd0, row}, 16'h000E);
    check_val("rst_key_code", {12'd0, key_code}, 16'd0);
    check_val("rst_key_valid", {15'd0, key_valid}, 16'd0);
    check_val("rst_key_down", {15'd0, key_down}, 16'd0);
  endtask

  // Must be called on a frame boundary; keys are then stable for nf frames.
  task automatic run_frames(input logic [15:0] mask, input int nf);
    keys = mask;
    repeat (nf * FRAME) step();
  endtask

  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K5  = 16'h0020;
  localparam logic [15:0] K4  = 16'h0010;
  localparam logic [15:0] K3  = 16'h0008;
  localparam logic [15:0] K15 = 16'h8000;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    apply_reset();

    // Idle scan, row stepping
    run_frames(16'h0000, 2);

    // Single key held: one pulse, no repeats, release
    run_frames(K9, 14);
    run_frames(16'h0000, 4);

    // Short presses never accepted
    run_frames(K3, 2);
    run_frames(16'h0000, 2);
    for (int i = 0; i < 3; i++) begin
      run_frames(K3, 2);
      run_frames(16'h0000, 1);
    end
    run_frames(16'h0000, 3);

    // Two keys from idle, then one released
    run_frames(K4 | K15, 10);
    run_frames(K4, 4);
    run_frames(16'h0000, 4);

    // No rollover
    run_frames(K9, 4);
    run_frames(K9 | K5, 4);
    run_frames(K5, 4);
    run_frames(16'h0000, 4);
    run_frames(K5, 4);
    run_frames(16'h0000, 4);

    // Reset mid-frame with key held and accepted
    run_frames(K9, 4);
    keys = K9;
    repeat (7) step();
    apply_reset();
    run_frames(K9, 4);
    run_frames(16'h0000, 4);

    // Randomized key activity with occasional resets
    for (int it = 0; it < 80; it++) begin
      int sel;
      int a;
      int b;
      logic [15:0] mask;
      sel  = $urandom_range(0, 9);
      a    = $urandom_range(0, 15);
      b    = $urandom_range(0, 15);
      mask = 16'd0;
      if (sel >= 3) mask[a] = 1'b1;
      if (sel >= 8) mask[b] = 1'b1;
      run_frames(mask, $urandom_range(1, 5));
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(1, FRAME - 1)) step();
        apply_reset();
      end
    end
    run_frames(16'h0000, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
